// File: rtl/nrzi_out_buf.sv
// nrzi_out_buf: one-entry valid/ready output buffer with sticky overrun on a dropped byte
module nrzi_out_buf (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       ready,
    output logic [7:0] data,
    output logic       valid,
    output logic       overrun
);
    logic accept;
    assign accept = valid && ready;
    // Load a new byte when the slot is free or being emptied this edge; otherwise drop it and flag
    always_ff @(posedge clk) begin
        if (reset) begin
            data    <= 8'h00;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else if (in_valid && (!valid || accept)) begin
            data  <= in_data;
            valid <= 1'b1;
        end else if (in_valid) begin
            overrun <= 1'b1;
        end else if (accept) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/nrzi_decoder.sv
// nrzi_decoder: NRZI line decoder with sync-byte framing, idle lock loss and a one-entry output buffer
module nrzi_decoder #(
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter int         IDLE_LIMIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       line_in,
    input  logic       sym_en,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       synced,
    output logic       overrun
);
    localparam logic HUNT   = 1'b0;
    localparam logic LOCKED = 1'b1;
    localparam int   ZW     = $clog2(IDLE_LIMIT + 1);
    localparam logic [ZW-1:0] ZMAX = ZW'(IDLE_LIMIT);

    logic          state, state_n;
    logic          prev_line;
    logic [7:0]    window, window_n;
    logic [7:0]    shreg, shreg_n, byte_data;
    logic [2:0]    cnt, cnt_n;
    logic [ZW-1:0] zrun, zrun_n;
    logic          dbit, byte_done;

    assign dbit      = line_in ^ prev_line;
    assign byte_data = {dbit, shreg[7:1]};
    assign synced    = state == LOCKED;

    // Next-state decode: window hunting, data shifting and zero-run lock loss, only on enabled symbols
    always_comb begin
        state_n   = state;
        window_n  = window;
        shreg_n   = shreg;
        cnt_n     = cnt;
        zrun_n    = zrun;
        byte_done = 1'b0;
        if (sym_en) begin
            window_n = {dbit, window[7:1]};
            zrun_n   = dbit ? '0 : (zrun == ZMAX ? zrun : zrun + 1'b1);
            if (state == HUNT) begin
                if (window_n == SYNC_BYTE) begin
                    state_n = LOCKED;
                    cnt_n   = 3'd0;
                    shreg_n = 8'h00;
                end
            end else begin
                shreg_n   = byte_data;
                cnt_n     = cnt + 3'd1;
                byte_done = cnt == 3'd7;
                if (zrun_n == ZMAX) begin
                    state_n = HUNT;
                    cnt_n   = 3'd0;
                    shreg_n = 8'h00;
                end
            end
        end
    end

    // Decode state register; prev_line only follows the line on sampled symbols
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= HUNT;
            prev_line <= 1'b0;
            window    <= 8'h00;
            shreg     <= 8'h00;
            cnt       <= 3'd0;
            zrun      <= '0;
        end else begin
            state     <= state_n;
            prev_line <= sym_en ? line_in : prev_line;
            window    <= window_n;
            shreg     <= shreg_n;
            cnt       <= cnt_n;
            zrun      <= zrun_n;
        end
    end

    nrzi_out_buf u_buf (
        .clk     (clk),
        .reset   (reset),
        .in_valid(byte_done),
        .in_data (byte_data),
        .ready   (data_ready),
        .data    (data_out),
        .valid   (data_valid),
        .overrun (overrun)
    );
endmodule

// File: tb/tb_nrzi_decoder.sv
// tb_nrzi_decoder: directed NRZI stimulus with a byte scoreboard and immediate-assertion checks
module tb_nrzi_decoder;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       line_in = 1'b0;
    logic       sym_en = 1'b0;
    logic       data_ready = 1'b0;
    logic [7:0] data_out;
    logic       data_valid, synced, overrun;
    logic       lvl = 1'b0;
    logic [7:0] exp_q[$];
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    nrzi_decoder dut (
        .clk       (clk),
        .reset     (reset),
        .line_in   (line_in),
        .sym_en    (sym_en),
        .data_out  (data_out),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .synced    (synced),
        .overrun   (overrun)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sym(input logic b);
        @(posedge clk);
        #1;
        lvl     = lvl ^ b;
        line_in = lvl;
        sym_en  = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) sym(b[i]);
    endtask

    task automatic finish_syms();
        @(posedge clk);
        #1;
        sym_en = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted byte must match the oldest expected byte
    always @(negedge clk) begin
        if (!reset && data_valid && data_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL sb_unexpected: observed %h expected none", data_out);
            end else begin
                check("sb_byte", data_out, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [7:0] b;
        tick();
        tick();
        check("rst_valid", 8'(data_valid), 8'h0);
        check("rst_data", data_out, 8'h00);
        check("rst_synced", 8'(synced), 8'h0);
        check("rst_overrun", 8'(overrun), 8'h0);
        reset = 1'b0;

        send_byte(8'hA5);
        finish_syms();
        check("sync_synced", 8'(synced), 8'h1);
        check("sync_novalid", 8'(data_valid), 8'h0);

        data_ready = 1'b1;
        exp_q.push_back(8'h3C);
        b = 8'h3C;
        for (int i = 0; i < 4; i++) sym(b[i]);
        tick();
        sym_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            line_in = ~line_in;
            tick();
        end
        for (int i = 4; i < 8; i++) sym(b[i]);
        finish_syms();
        check("b3c_valid", 8'(data_valid), 8'h1);
        check("b3c_data", data_out, 8'h3C);
        tick();
        check("b3c_one_cycle", 8'(data_valid), 8'h0);

        data_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_byte(8'h11);
        send_byte(8'h22);
        finish_syms();
        check("ovr_valid", 8'(data_valid), 8'h1);
        check("ovr_keep", data_out, 8'h11);
        check("ovr_flag", 8'(overrun), 8'h1);
        data_ready = 1'b1;
        tick();
        check("ovr_drain", 8'(data_valid), 8'h0);

        data_ready = 1'b0;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h55);
        send_byte(8'h11);
        b = 8'h55;
        for (int i = 0; i < 7; i++) sym(b[i]);
        sym(b[7]);
        data_ready = 1'b1;
        finish_syms();
        check("b2b_valid", 8'(data_valid), 8'h1);
        check("b2b_data", data_out, 8'h55);
        check("b2b_overrun_sticky", 8'(overrun), 8'h1);
        tick();
        check("b2b_drain", 8'(data_valid), 8'h0);

        exp_q.push_back(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        finish_syms();
        check("idle_unlock", 8'(synced), 8'h0);
        send_byte(8'hFF);
        finish_syms();
        tick();
        check("ff_novalid", 8'(data_valid), 8'h0);
        check("ff_nosync", 8'(synced), 8'h0);

        data_ready = 1'b0;
        send_byte(8'hA5);
        send_byte(8'h3C);
        b = 8'h0F;
        for (int i = 0; i < 4; i++) sym(b[i]);
        tick();
        check("pre_rst_valid", 8'(data_valid), 8'h1);
        reset  = 1'b1;
        sym_en = 1'b0;
        tick();
        check("mid_rst_valid", 8'(data_valid), 8'h0);
        check("mid_rst_data", data_out, 8'h00);
        check("mid_rst_synced", 8'(synced), 8'h0);
        check("mid_rst_overrun", 8'(overrun), 8'h0);
        reset      = 1'b0;
        lvl        = 1'b0;
        line_in    = 1'b0;
        data_ready = 1'b1;
        exp_q.push_back(8'h96);
        send_byte(8'hA5);
        send_byte(8'h96);
        finish_syms();
        check("fresh_valid", 8'(data_valid), 8'h1);
        check("fresh_data", data_out, 8'h96);
        tick();
        tick();
        check("sb_empty", 8'(exp_q.size()), 8'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/nrzi_decoder.md
NRZI_DECODER -- requirements
Module: nrzi_decoder

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, sync pattern that must be received before data is framed.
REQ-002 SHALL have parameter IDLE_LIMIT, default 16, the number of consecutive decoded zeros that drops lock.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-005 SHALL have port line_in, input, 1 bit: NRZI line, where a level change means 1 and no change means 0 (the line a toggle flip-flop drives).
REQ-006 SHALL have port sym_en, input, 1 bit: line_in is sampled only on edges where sym_en=1.
REQ-007 SHALL have port data_out, output, 8 bits: decoded byte, LSB received first.
REQ-008 SHALL have port data_valid, output, 1 bit: data_out holds an unconsumed byte.
REQ-009 SHALL have port data_ready, input, 1 bit: consumer accepts the byte on an edge where data_valid=1 and data_ready=1.
REQ-010 SHALL have port synced, output, 1 bit: high while the block is in the LOCKED state.
REQ-011 SHALL have port overrun, output, 1 bit: sticky flag, set when a byte is lost.

Function
REQ-012 SHALL decode each sampled symbol as bit = line_in XOR prev_line, then set prev_line = line_in; sym_en=0 leaves all decode state unchanged.
REQ-013 SHALL implement states HUNT and LOCKED.
REQ-014 In HUNT, SHALL shift each decoded bit into an 8-bit window (new bit at MSB, so the window reads LSB-first); when the window equals SYNC_BYTE after a shift, SHALL go to LOCKED with bit counter 0; the sync byte itself SHALL NOT be output.
REQ-015 In LOCKED, SHALL shift decoded bits into the data shift register; on the 8th bit (counter 7->0 wrap), the completed byte SHALL be offered to the output buffer on that same edge.
REQ-016 Latency: data_valid SHALL be visible the cycle after the edge that samples the 8th symbol.
REQ-017 SHALL track consecutive decoded zeros in both states (saturating); reaching IDLE_LIMIT in LOCKED SHALL return to HUNT, discard any partial byte and clear the counter; the output buffer SHALL be kept.
REQ-018 Output buffer: one entry; data_valid and data_out SHALL hold until accepted; data_out SHALL be stable while data_valid=1.
REQ-019 A byte completes while the buffer is full and not accepted this edge: SHALL drop the new byte, keep the old byte, and set overrun.
REQ-020 A byte completes on the same edge the buffer is accepted: SHALL load the new byte, and data_valid SHALL stay 1 with no bubble.
REQ-021 Accept with no new byte: data_valid SHALL fall the next cycle.
REQ-022 A sync match in LOCKED SHALL NOT be treated specially; it is data.

Reset
REQ-023 On reset=1 at a clock edge, SHALL reset to: state HUNT, prev_line=0, window 8'h00, shift register 0, counter 0, zero-run 0, data_out 8'h00, data_valid 0, synced 0, overrun 0.
REQ-024 Reset SHALL override all other inputs, including mid-byte and with data_valid=1; the pending byte SHALL be discarded.

Structure
REQ-025 SHALL be a single module with no shared package; SYNC_BYTE and IDLE_LIMIT are parameters; state encoding SHALL be localparams.
REQ-026 MAY use one sub-module, nrzi_out_buf (the one-entry valid/ready buffer with overrun detect).

Verification
REQ-027 Reset then drive sync bits 1,0,1,0,0,1,0,1 as NRZI from line 0 (levels 1,1,0,0,0,1,1,0) -> synced=1 on the next cycle; data_valid stays 0.
REQ-028 Send sync then 8'h3C with data_ready=1 -> data_valid=1 with data_out=8'h3C one cycle after the 8th symbol, for exactly one cycle.
REQ-029 data_ready=0, send 8'h11 then 8'h22 -> data_out stays 8'h11 and overrun=1; assert ready -> valid falls next cycle.
REQ-030 Hold data_ready=1 with the 8th bit of 8'h55 sampled on the same edge that 8'h11 is accepted -> data_valid stays 1 and data_out=8'h55.
REQ-031 Locked, 16 constant-level symbols -> synced=0; a later 8'hFF without sync -> no data_valid.
REQ-032 Pulse reset after 4 data bits with data_valid=1 -> all outputs are at their reset values next cycle; a fresh sync+byte decodes correctly.
